dmem_model: RTL

- Parametrised, synthesizable-style data memory for the RV32I core's d_mem port.
- Replaces the word-only bench RAM: byte-lane writes, selectable read latency, deterministic out-of-range reads, and a memory-mapped completion register (tohost).
- The completion register lets benches end on program completion instead of a fixed cycle budget.
- Sits between cpu_top's d_mem_* port and the testbench; the bench only watches done/pass.

---
 rtl/dmem_pkg.sv | 32 +++
 rtl/dmem_write_log.sv | 45 ++++
 rtl/dmem_model.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the dmem_model data memory: FSM encoding,
// fixed read patterns and the packing of write-log entries.
package dmem_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } dmem_state_e;

  localparam logic [31:0] OOB_PATTERN = 32'hDEAD_BEEF;
  localparam logic [31:0] TOHOST_PASS = 32'h0000_0001;

  localparam int LOG_WEN_W    = 4;
  localparam int LOG_DATA_W   = 32;
  localparam int LOG_ADDR_W   = 32;
  localparam int LOG_WEN_LSB  = 0;
  localparam int LOG_DATA_LSB = LOG_WEN_LSB + LOG_WEN_W;
  localparam int LOG_ADDR_LSB = LOG_DATA_LSB + LOG_DATA_W;
  localparam int LOG_ENTRY_W  = LOG_ADDR_LSB + LOG_ADDR_W;

  function automatic logic [LOG_ENTRY_W-1:0] pack_log_entry(input logic [31:0] addr,
                                                            input logic [31:0] data,
                                                            input logic [3:0]  wen);
    logic [LOG_ENTRY_W-1:0] e;
    e = '0;
    e[LOG_ADDR_LSB +: LOG_ADDR_W] = addr;
    e[LOG_DATA_LSB +: LOG_DATA_W] = data;
    e[LOG_WEN_LSB  +: LOG_WEN_W]  = wen;
    return e;
  endfunction

endpackage

// File: rtl/dmem_write_log.sv
// Circular record of the most recent accepted array writes; index 0 reads the
// newest entry, indices at or beyond the valid count read as zero.
module dmem_write_log
  import dmem_pkg::*;
#(
  parameter int unsigned LOG_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [31:0]                  addr,
  input  logic [31:0]                  data,
  input  logic [3:0]                   wen,
  input  logic [$clog2(LOG_DEPTH)-1:0] log_idx,
  output logic [LOG_ENTRY_W-1:0]       log_data,
  output logic [$clog2(LOG_DEPTH):0]   log_count
);

  localparam int IW = $clog2(LOG_DEPTH);

  logic [LOG_ENTRY_W-1:0] entries [LOG_DEPTH];
  logic [IW-1:0]          wr_ptr;
  logic [IW-1:0]          rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      log_count <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + IW'(1);
      if (log_count != (IW+1)'(LOG_DEPTH))
        log_count <= log_count + (IW+1)'(1);
    end
  end

  // Entry storage carries no reset; log_count gates what is visible.
  always_ff @(posedge clk) begin
    if (push)
      entries[wr_ptr] <= pack_log_entry(addr, data, wen);
  end

  assign rd_ptr   = wr_ptr - IW'(1) - log_idx;
  assign log_data = ({1'b0, log_idx} < log_count) ? entries[rd_ptr] : '0;

endmodule

// File: rtl/dmem_model.sv
// Data memory for the RV32I d_mem port with byte-lane writes, selectable read
// latency and a tohost completion register. Optional write log: DMEM_WRITE_LOG_EN.
//
// state   | meaning
// RUN     | normal operation, array writes and tohost completion accepted
// DONE    | completion seen; writes dropped, reads still served until reset
module dmem_model
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS  = 1024,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned READ_LATENCY = 0,
  parameter logic [31:0] TOHOST_ADDR  = 32'h0000_FFF0,
  parameter string       INIT_FILE    = "",
  parameter int unsigned LOG_DEPTH    = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [31:0]                  d_mem_addr,
  input  logic [31:0]                  d_mem_wdata,
  input  logic [3:0]                   d_mem_wen,
  output logic [31:0]                  d_mem_rdata,
  output logic                         done,
  output logic                         pass,
  output logic [30:0]                  fail_code,
  output logic                         err_oob,
  output logic [15:0]                  wr_count,
  input  logic [$clog2(LOG_DEPTH)-1:0] log_idx,
  output logic [LOG_ENTRY_W-1:0]       log_data,
  output logic [$clog2(LOG_DEPTH):0]   log_count
);

  localparam int          AW          = $clog2(DEPTH_WORDS);
  localparam logic [32:0] ARRAY_BYTES = 33'(DEPTH_WORDS) << 2;

  dmem_state_e state;

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] addr_w;
  logic [32:0] diff;
  logic [AW-1:0] idx;
  logic        in_range;
  logic        is_tohost;
  logic        running;
  logic        wr_accept;
  logic        tohost_hit;
  logic        oob_cycle;
  logic [31:0] rd_word;
  logic        unused_sigs;

  // A borrow out of the 33-bit subtraction means the address sits below BASE_ADDR.
  assign addr_w    = {d_mem_addr[31:2], 2'b00};
  assign diff      = {1'b0, addr_w} - {1'b0, BASE_ADDR};
  assign in_range  = !diff[32] && ({1'b0, diff[31:0]} < ARRAY_BYTES);
  assign idx       = diff[AW+1:2];
  assign is_tohost = (addr_w == TOHOST_ADDR);

  assign running    = (state == ST_RUN);
  assign wr_accept  = running && (d_mem_wen != 4'b0000) && in_range;
  assign tohost_hit = running && is_tohost && (d_mem_wen == 4'b1111) && d_mem_wdata[0];
  assign oob_cycle  = !in_range && !is_tohost;

  always_ff @(posedge clk) begin
    if (wr_accept) begin
      for (int i = 0; i < 4; i++) begin
        if (d_mem_wen[i])
          mem[idx][8*i +: 8] <= d_mem_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RUN;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_code <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (tohost_hit) begin
            state     <= ST_DONE;
            done      <= 1'b1;
            pass      <= (d_mem_wdata == TOHOST_PASS);
            fail_code <= d_mem_wdata[31:1];
          end
        end
        default: state <= ST_DONE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_count <= '0;
      err_oob  <= 1'b0;
    end else begin
      if (wr_accept && (wr_count != 16'hFFFF))
        wr_count <= wr_count + 16'd1;
      if (oob_cycle)
        err_oob <= 1'b1;
    end
  end

  assign rd_word = in_range  ? mem[idx] :
                   is_tohost ? {fail_code, done} : OOB_PATTERN;

  generate
    if (READ_LATENCY == 0) begin : g_comb_rd
      assign d_mem_rdata = rd_word;
    end else begin : g_reg_rd
      logic [31:0] rdata_q;
      // Sampled before the same-edge array write lands: read-before-write.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata_q <= '0;
        else        rdata_q <= rd_word;
      end
      assign d_mem_rdata = rdata_q;
    end
  endgenerate

`ifdef DMEM_WRITE_LOG_EN
  dmem_write_log #(
    .LOG_DEPTH (LOG_DEPTH)
  ) u_write_log (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (wr_accept),
    .addr      (d_mem_addr),
    .data      (d_mem_wdata),
    .wen       (d_mem_wen),
    .log_idx   (log_idx),
    .log_data  (log_data),
    .log_count (log_count)
  );
`else
  assign log_data  = '0;
  assign log_count = '0;
`endif

  assign unused_sigs = ^{d_mem_addr[1:0], log_idx};

endmodule
